// File: rtl/adder_share_ctrl_pkg.sv
// adder_share_ctrl_pkg: shared widths, FSM encodings and saturation limits
package adder_share_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};
endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting the search at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    id,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any_req
);
  localparam logic [ID_W:0] L_N = (ID_W+1)'(NUM_REQ);
  logic [2*NUM_REQ-1:0] w_rot;
  logic [ID_W-1:0]      w_off;
  logic [ID_W:0]        w_sum;
  assign w_rot = {req, req} >> ptr;
  // Lowest offset from the pointer wins, so scan downwards and let the last hit stick
  always_comb begin
    w_off = '0;
    any_req = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = ID_W'(k);
        any_req = 1'b1;
      end
    end
  end
  assign w_sum = {1'b0, ptr} + {1'b0, w_off};
  assign id = (w_sum >= L_N) ? ID_W'(w_sum - L_N) : w_sum[ID_W-1:0];
  assign gnt = any_req ? (NUM_REQ'(1) << id) : '0;
endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: round-robin time-sharing controller for one external signed adder
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_REQ = 2,
  parameter int ID_W = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] op_a,
  input  logic [NUM_REQ*WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic [WIDTH-1:0]         result,
  output logic                     ovf
);
  localparam logic [WIDTH-1:0] L_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_ptr, r_id, r_done_id;
  logic [NUM_REQ-1:0] r_gnt;
  logic [WIDTH-1:0]   r_a, r_b, r_res;
  logic               r_ovf, r_done;
  logic [WIDTH-1:0]   w_opa [NUM_REQ];
  logic [WIDTH-1:0]   w_opb [NUM_REQ];
  logic [ID_W-1:0]    w_id;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any, w_ovf;
  logic [WIDTH-1:0]   w_res;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign w_opa[g] = op_a[g*WIDTH +: WIDTH];
    assign w_opb[g] = op_b[g*WIDTH +: WIDTH];
  end
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req), .ptr(r_ptr), .id(w_id), .gnt(w_gnt), .any_req(w_any)
  );
  assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (add_sum[WIDTH-1] != r_a[WIDTH-1]);
  assign w_res = (SATURATE && w_ovf) ? (r_a[WIDTH-1] ? L_MIN : L_MAX) : add_sum;
  // IDLE grants and latches operands, EXEC captures the sum, DONE holds the done pulse for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr <= '0;
      r_id <= '0;
      r_done_id <= '0;
      r_gnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_res <= '0;
      r_ovf <= 1'b0;
      r_done <= 1'b0;
    end else if (r_state == S_IDLE && w_any) begin
      r_state <= S_EXEC;
      r_a <= w_opa[w_id];
      r_b <= w_opb[w_id];
      r_id <= w_id;
      r_gnt <= w_gnt;
    end else if (r_state == S_EXEC) begin
      r_state <= S_DONE;
      r_res <= w_res;
      r_ovf <= w_ovf;
      r_done <= 1'b1;
      r_done_id <= r_id;
      r_gnt <= '0;
      r_ptr <= (r_id == ID_W'(NUM_REQ-1)) ? '0 : r_id + 1'b1;
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
      r_done <= 1'b0;
    end
  end
  assign gnt = r_gnt;
  assign busy = (r_state != S_IDLE);
  assign add_a = r_a;
  assign add_b = r_b;
  assign done = r_done;
  assign done_id = r_done_id;
  assign result = r_res;
  assign ovf = r_ovf;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: scoreboard bench driving a wrapping and a saturating instance in lockstep
module tb_adder_share_ctrl;
  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       ovf;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] op_a = '0, op_b = '0;
  logic [1:0]  gnt0, gnt1;
  logic        busy0, busy1, done0, done1, ovf0, ovf1, done_id0, done_id1;
  logic [7:0]  add_a0, add_b0, add_a1, add_b1, sum0, sum1, result0, result1;
  exp_t        q0[$], q1[$];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign sum0 = add_a0 + add_b0;
  assign sum1 = add_a1 + add_b1;

  adder_share_ctrl #(.WIDTH(8), .NUM_REQ(2), .ID_W(1), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt0), .busy(busy0),
    .add_a(add_a0), .add_b(add_b0), .add_sum(sum0), .done(done0), .done_id(done_id0),
    .result(result0), .ovf(ovf0)
  );
  adder_share_ctrl #(.WIDTH(8), .NUM_REQ(2), .ID_W(1), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt1), .busy(busy1),
    .add_a(add_a1), .add_b(add_b1), .add_sum(sum1), .done(done1), .done_id(done_id1),
    .result(result1), .ovf(ovf1)
  );

  function automatic exp_t model(logic id, logic [7:0] a, logic [7:0] b, bit sat);
    logic [7:0] s;
    logic o;
    s = a + b;
    o = (a[7] == b[7]) && (s[7] != a[7]);
    model.id = id;
    model.ovf = o;
    model.res = (sat && o) ? (a[7] ? 8'h80 : 8'h7F) : s;
  endfunction

  task automatic push(logic id, logic [7:0] a, logic [7:0] b);
    q0.push_back(model(id, a, b, 1'b0));
    q1.push_back(model(id, a, b, 1'b1));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt0 != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL wrap_unexpected_done: got id=%0d result=%h ovf=%0d, expected no done", done_id0, result0, ovf0);
      end else begin
        e = q0.pop_front();
        if ({done_id0, result0, ovf0} !== e) begin
          errors++;
          $display("FAIL wrap_result: got id=%0d result=%h ovf=%0d, expected id=%0d result=%h ovf=%0d",
                   done_id0, result0, ovf0, e.id, e.res, e.ovf);
        end
      end
    end
    if (done1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sat_unexpected_done: got id=%0d result=%h ovf=%0d, expected no done", done_id1, result1, ovf1);
      end else begin
        e = q1.pop_front();
        if ({done_id1, result1, ovf1} !== e) begin
          errors++;
          $display("FAIL sat_result: got id=%0d result=%h ovf=%0d, expected id=%0d result=%h ovf=%0d",
                   done_id1, result1, ovf1, e.id, e.res, e.ovf);
        end
      end
    end
  end

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({gnt0, busy0, add_a0, add_b0, done0, done_id0, result0, ovf0} !== '0) begin
      errors++;
      $display("FAIL reset_wrap: got gnt=%b busy=%b a=%h b=%h done=%b id=%b res=%h ovf=%b, expected all 0",
               gnt0, busy0, add_a0, add_b0, done0, done_id0, result0, ovf0);
    end
    checks++;
    if ({gnt1, busy1, add_a1, add_b1, done1, done_id1, result1, ovf1} !== '0) begin
      errors++;
      $display("FAIL reset_sat: got gnt=%b busy=%b a=%h b=%h done=%b id=%b res=%h ovf=%b, expected all 0",
               gnt1, busy1, add_a1, add_b1, done1, done_id1, result1, ovf1);
    end
  endtask

  task automatic test_single();
    bit ok;
    op_a[7:0] = 8'h05;
    op_b[7:0] = 8'h03;
    req = 2'b01;
    push(1'b0, 8'h05, 8'h03);
    wait_gnt(ok);
    checks++;
    if (!ok || gnt0 !== 2'b01 || busy0 !== 1'b1 || add_a0 !== 8'h05 || add_b0 !== 8'h03 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: got ok=%0d gnt=%b busy=%b a=%h b=%h done=%b, expected gnt=01 busy=1 a=05 b=03 done=0",
               ok, gnt0, busy0, add_a0, add_b0, done0);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || gnt0 !== 2'b00 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got done=%b gnt=%b busy=%b, expected done=1 gnt=00 busy=1", done0, gnt0, busy0);
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || result0 !== 8'h08) begin
      errors++;
      $display("FAIL single_idle: got done=%b busy=%b result=%h, expected done=0 busy=0 result=08", done0, busy0, result0);
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic [1:0] want;
    apply_reset();
    op_a = {8'h20, 8'h10};
    op_b = {8'h02, 8'h01};
    req = 2'b11;
    push(1'b0, 8'h10, 8'h01);
    push(1'b1, 8'h20, 8'h02);
    push(1'b0, 8'h10, 8'h01);
    for (int k = 0; k < 3; k++) begin
      want = (k % 2 == 1) ? 2'b10 : 2'b01;
      wait_gnt(ok);
      checks++;
      if (!ok || gnt0 !== want || gnt1 !== want) begin
        errors++;
        $display("FAIL contention_gnt%0d: got ok=%0d gnt=%b/%b, expected %b", k, ok, gnt0, gnt1, want);
      end
      @(negedge clk);
      if (k == 2) req = 2'b00;
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    ta = '{8'h7F, 8'h80, 8'hFE};
    tb = '{8'h01, 8'hFF, 8'h01};
    for (int k = 0; k < 3; k++) begin
      op_a[7:0] = ta[k];
      op_b[7:0] = tb[k];
      req = 2'b01;
      push(1'b0, ta[k], tb[k]);
      wait_gnt(ok);
      checks++;
      if (!ok || add_a1 !== ta[k] || add_b1 !== tb[k]) begin
        errors++;
        $display("FAIL overflow_op%0d: got ok=%0d a=%h b=%h, expected a=%h b=%h", k, ok, add_a1, add_b1, ta[k], tb[k]);
      end
      @(negedge clk);
      req = 2'b00;
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    op_a[7:0] = 8'h05;
    op_b[7:0] = 8'h03;
    req = 2'b01;
    wait_gnt(ok);
    reset = 1'b1;
    req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (!ok || {gnt0, busy0, add_a0, add_b0, done0, done_id0, result0, ovf0} !== '0 ||
        {gnt1, busy1, add_a1, add_b1, done1, done_id1, result1, ovf1} !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: got ok=%0d gnt=%b busy=%b done=%b res=%h/%h a=%h, expected all 0",
               ok, gnt0, busy0, done0, result0, result1, add_a0);
    end
    op_a = {8'h30, 8'h05};
    op_b = {8'h04, 8'h03};
    req = 2'b11;
    push(1'b0, 8'h05, 8'h03);
    push(1'b1, 8'h30, 8'h04);
    wait_gnt(ok);
    checks++;
    if (!ok || gnt0 !== 2'b01) begin
      errors++;
      $display("FAIL mid_reset_ptr: got ok=%0d gnt=%b, expected 01", ok, gnt0);
    end
    @(negedge clk);
    req = 2'b10;
    wait_gnt(ok);
    checks++;
    if (!ok || gnt0 !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset_req1: got ok=%0d gnt=%b, expected 10", ok, gnt0);
    end
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_drop();
    bit ok;
    int seen;
    op_a[7:0] = 8'h11;
    op_b[7:0] = 8'h22;
    req = 2'b01;
    push(1'b0, 8'h11, 8'h22);
    wait_gnt(ok);
    op_a[7:0] = 8'h70;
    req = 2'b00;
    checks++;
    if (!ok || add_a0 !== 8'h11) begin
      errors++;
      $display("FAIL drop_grant: got ok=%0d a=%h, expected a=11", ok, add_a0);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || result0 !== 8'h33) begin
      errors++;
      $display("FAIL drop_done: got done=%b result=%h, expected done=1 result=33", done0, result0);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (gnt0 != 2'b00 || busy0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL drop_no_regrant: got %0d busy cycles, expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_mid_reset();
    test_drop();
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending results, expected 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Time-multiplexes the single shared 8-bit signed adder between NUM_REQ requesters, e.g. the datapath's PC/branch-target path and the debug unit.
- Arbitrates requests round-robin, latches the granted operands and drives them onto the adder.
- Captures the adder sum one cycle later, flags signed overflow, and returns the result with a one-cycle done pulse tagged with the requester id.
- Sits between the requesters and the existing combinational adder instance; the adder itself stays outside this block.

Parameters:
- WIDTH, 8, operand/result width; matches the shared adder.
- NUM_REQ, 2, number of requesters (2..4).
- ID_W, 1, width of requester id; must equal clog2(NUM_REQ).
- SATURATE, 0, 1 = clamp result on signed overflow; 0 = wrap.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  level request per requester
- op_a  in  NUM_REQ*WIDTH  operand A, slice i belongs to requester i
- op_b  in  NUM_REQ*WIDTH  operand B, slice i belongs to requester i
- gnt  out  NUM_REQ  one-hot, high during the EXEC cycle for the granted requester
- busy  out  1  high in EXEC and DONE
- add_a  out  WIDTH  registered operand A driven to the shared adder
- add_b  out  WIDTH  registered operand B driven to the shared adder
- add_sum  in  WIDTH  combinational sum returned from the shared adder
- done  out  1  one-cycle pulse: result valid
- done_id  out  ID_W  requester the result belongs to; valid while done=1
- result  out  WIDTH  registered sum, held until the next capture
- ovf  out  1  signed overflow of the last capture, held with result

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - state = IDLE.
  - gnt, busy, done, ovf = 0.
  - add_a, add_b, result, done_id = 0.
  - Priority pointer = requester 0 highest.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any req bit is high at the clock edge, select the winner round-robin: search starts at pointer, wraps modulo NUM_REQ.
  - Latch the winner's op_a/op_b slices into add_a/add_b and the winner id internally.
  - Set gnt one-hot and busy=1, then go to EXEC.
  - If no request, stay in IDLE; all outputs hold.
- EXEC (exactly 1 cycle):
  - At the edge, capture result.
    - SATURATE=0: result = add_sum.
    - SATURATE=1 with overflow: result = 0x7F if add_a is positive, 0x80 if negative.
  - Overflow rule: ovf = (add_a[MSB]==add_b[MSB]) && (add_sum[MSB]!=add_a[MSB]). ovf is reported in both modes.
  - Set done=1 and done_id = winner id.
  - Clear gnt; keep busy=1.
  - Pointer becomes winner+1 mod NUM_REQ.
  - Go to DONE.
- DONE (1 cycle):
  - done=1, busy=1, result/ovf valid.
  - At the edge, clear done and busy and go to IDLE.
  - req is not sampled in DONE, so a requester may still hold req while it observes done.
- Latency: req sampled at edge N -> gnt high in cycle N+1 -> done high in cycle N+2.
- Throughput: one operation per 3 cycles per block.
- Handshake:
  - A requester holds req and its operands stable until done with a matching done_id. Operands are sampled only at the grant edge; later changes are ignored.
  - Dropping req after grant does not cancel the operation; done still pulses.
  - A req still high in the first IDLE cycle after DONE starts a new operation.
- Simultaneous requests: exactly one grant per operation. The round-robin pointer guarantees each requester is served within NUM_REQ operations.
- Reset asserted in any state: the in-flight operation is discarded, no done pulse, all outputs and the pointer return to reset values on that edge.
- Width rule: the adder is WIDTH-bit signed two's complement; no carry-out is exported.

Decomposition:
- Shared package:
  - WIDTH default and state encodings (IDLE=2'd0, EXEC=2'd1, DONE=2'd2).
  - SAT_MAX/SAT_MIN constants (0x7F/0x80 for WIDTH=8).
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, pointer.
  - Outputs: winner id, one-hot grant, any_req.
- The FSM, operand registers and result capture stay in adder_share_ctrl.

Test Plan:
- Single requester: reset 2 cycles, then req=01, a0=0x05, b0=0x03 -> gnt=01 in cycle N+1; done=1, done_id=0, result=0x08, ovf=0 in cycle N+2.
- Contention: req=11 held, a0+b0=0x10+0x01, a1+b1=0x20+0x02 -> first done_id=0 result=0x11, second done_id=1 result=0x22, third done_id=0; grants alternate strictly.
- Overflow wrap: SATURATE=0, 0x7F+0x01 -> result=0x80, ovf=1. Negative case: 0x80+0xFF -> result=0x7F, ovf=1.
- Saturation: SATURATE=1 with the same stimuli -> results 0x7F and 0x80 respectively, ovf=1. Non-overflow case 0xFE+0x01 -> result=0xFF, ovf=0.
- Mid-operation reset: assert reset during the EXEC cycle -> no done pulse, next-cycle outputs all 0. A req=10 then issued -> requester 1 is served; pointer priority is back to requester 0 when both request.
- Request drop and operand change: change a0 and drop req the cycle after grant -> done still pulses with the originally sampled operands' sum; the block returns to IDLE with no further grant.
